// File: rtl/controller.sv
// rtl/controller.sv - Multi-cycle instruction controller: fetch, decode and per-opcode datapath control
//
// Ports:
//   clk, rst               single rising-edge clock, synchronous active-high reset
//   start                  leaves INIT and begins fetching (ignored elsewhere)
//   I_addr, I_rd, I_data   instruction memory: address/read strobe out, word in (same cycle)
//   D_addr, D_rd, D_wr     data memory address and strobes
//   RF_W_data              constant for write-back (LOADC)
//   RF_W_addr, RF_W_wr     register-file write port
//   RF_Rp_addr, RF_Rp_rd   register-file read port P
//   RF_Rq_addr, RF_Rq_rd   register-file read port Q
//   RF_s1, RF_s0           write-back select: 00 ALU, 01 data memory, 10 constant
//   alu_s1, alu_s0         ALU op: 00 pass A, 01 A+B, 10 A-B
//   RF_Rp_zero             Rp read data equals zero
//   halted                 high while in HALT
module controller #(
    parameter int PC_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic [PC_W-1:0] I_addr,
    output logic            I_rd,
    input  logic [15:0]     I_data,
    output logic [7:0]      D_addr,
    output logic            D_rd,
    output logic            D_wr,
    output logic [7:0]      RF_W_data,
    output logic [3:0]      RF_W_addr,
    output logic            RF_W_wr,
    output logic [3:0]      RF_Rp_addr,
    output logic            RF_Rp_rd,
    output logic [3:0]      RF_Rq_addr,
    output logic            RF_Rq_rd,
    output logic            RF_s1,
    output logic            RF_s0,
    output logic            alu_s1,
    output logic            alu_s0,
    input  logic            RF_Rp_zero,
    output logic            halted
);

    typedef enum logic [3:0] {
        S_INIT,
        S_FETCH,
        S_DECODE,
        S_LOAD,
        S_STORE,
        S_ADD,
        S_SUB,
        S_LOADC,
        S_JMPZ,
        S_JMPZ_TAKE,
        S_HALT
    } state_t;

    localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [15:0]     ir_q, ir_d;

    logic [PC_W-1:0] i_addr_q, i_addr_d;
    logic            i_rd_q, i_rd_d;
    logic [7:0]      d_addr_q, d_addr_d;
    logic            d_rd_q, d_rd_d;
    logic            d_wr_q, d_wr_d;
    logic [7:0]      w_data_q, w_data_d;
    logic [3:0]      w_addr_q, w_addr_d;
    logic            w_wr_q, w_wr_d;
    logic [3:0]      rp_addr_q, rp_addr_d;
    logic            rp_rd_q, rp_rd_d;
    logic [3:0]      rq_addr_q, rq_addr_d;
    logic            rq_rd_q, rq_rd_d;
    logic [1:0]      rf_s_q, rf_s_d;
    logic [1:0]      alu_s_q, alu_s_d;
    logic            halted_q, halted_d;

    logic [3:0]      op_q;
    logic [PC_W-1:0] d_sext;

    assign op_q   = ir_q[15:12];
    // Jump offset is sign-extended to the PC width; wrap-around is intentional.
    assign d_sext = PC_W'($signed(ir_q[7:0]));

    // Next-state and next-PC/IR.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        case (state_q)
            S_INIT: begin
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                ir_d    = I_data;
                pc_d    = pc_q + PC_ONE;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                case (op_q)
                    4'b0000: state_d = S_LOAD;
                    4'b0001: state_d = S_STORE;
                    4'b0010: state_d = S_ADD;
                    4'b0011: state_d = S_LOADC;
                    4'b0100: state_d = S_SUB;
                    4'b0101: state_d = S_JMPZ;
                    4'b1111: state_d = S_HALT;
                    default: state_d = S_FETCH;
                endcase
            end
            S_JMPZ: begin
                state_d = RF_Rp_zero ? S_JMPZ_TAKE : S_FETCH;
            end
            S_JMPZ_TAKE: begin
                // PC already points past the jump, so subtract one to make
                // the target relative to the jump's own address.
                pc_d    = pc_q + d_sext - PC_ONE;
                state_d = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Outputs are registered: they are decoded from the state being entered
    // so that each state's strobes are valid for exactly that state's cycle.
    always_comb begin
        i_addr_d  = '0;
        i_rd_d    = 1'b0;
        d_addr_d  = '0;
        d_rd_d    = 1'b0;
        d_wr_d    = 1'b0;
        w_data_d  = '0;
        w_addr_d  = '0;
        w_wr_d    = 1'b0;
        rp_addr_d = '0;
        rp_rd_d   = 1'b0;
        rq_addr_d = '0;
        rq_rd_d   = 1'b0;
        rf_s_d    = 2'b00;
        alu_s_d   = 2'b00;
        halted_d  = 1'b0;
        case (state_d)
            S_FETCH: begin
                i_addr_d = pc_d;
                i_rd_d   = 1'b1;
            end
            S_LOAD: begin
                d_addr_d = ir_d[7:0];
                d_rd_d   = 1'b1;
                w_addr_d = ir_d[11:8];
                w_wr_d   = 1'b1;
                rf_s_d   = 2'b01;
            end
            S_STORE: begin
                d_addr_d  = ir_d[7:0];
                d_wr_d    = 1'b1;
                rp_addr_d = ir_d[11:8];
                rp_rd_d   = 1'b1;
            end
            S_ADD, S_SUB: begin
                rp_addr_d = ir_d[7:4];
                rp_rd_d   = 1'b1;
                rq_addr_d = ir_d[3:0];
                rq_rd_d   = 1'b1;
                w_addr_d  = ir_d[11:8];
                w_wr_d    = 1'b1;
                rf_s_d    = 2'b00;
                alu_s_d   = (state_d == S_ADD) ? 2'b01 : 2'b10;
            end
            S_LOADC: begin
                w_data_d = ir_d[7:0];
                w_addr_d = ir_d[11:8];
                w_wr_d   = 1'b1;
                rf_s_d   = 2'b10;
            end
            S_JMPZ: begin
                rp_addr_d = ir_d[11:8];
                rp_rd_d   = 1'b1;
            end
            S_HALT: begin
                halted_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_INIT;
            pc_q      <= '0;
            ir_q      <= '0;
            i_addr_q  <= '0;
            i_rd_q    <= 1'b0;
            d_addr_q  <= '0;
            d_rd_q    <= 1'b0;
            d_wr_q    <= 1'b0;
            w_data_q  <= '0;
            w_addr_q  <= '0;
            w_wr_q    <= 1'b0;
            rp_addr_q <= '0;
            rp_rd_q   <= 1'b0;
            rq_addr_q <= '0;
            rq_rd_q   <= 1'b0;
            rf_s_q    <= 2'b00;
            alu_s_q   <= 2'b00;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            i_addr_q  <= i_addr_d;
            i_rd_q    <= i_rd_d;
            d_addr_q  <= d_addr_d;
            d_rd_q    <= d_rd_d;
            d_wr_q    <= d_wr_d;
            w_data_q  <= w_data_d;
            w_addr_q  <= w_addr_d;
            w_wr_q    <= w_wr_d;
            rp_addr_q <= rp_addr_d;
            rp_rd_q   <= rp_rd_d;
            rq_addr_q <= rq_addr_d;
            rq_rd_q   <= rq_rd_d;
            rf_s_q    <= rf_s_d;
            alu_s_q   <= alu_s_d;
            halted_q  <= halted_d;
        end
    end

    assign I_addr     = i_addr_q;
    assign I_rd       = i_rd_q;
    assign D_addr     = d_addr_q;
    assign D_rd       = d_rd_q;
    assign D_wr       = d_wr_q;
    assign RF_W_data  = w_data_q;
    assign RF_W_addr  = w_addr_q;
    assign RF_W_wr    = w_wr_q;
    assign RF_Rp_addr = rp_addr_q;
    assign RF_Rp_rd   = rp_rd_q;
    assign RF_Rq_addr = rq_addr_q;
    assign RF_Rq_rd   = rq_rd_q;
    assign RF_s1      = rf_s_q[1];
    assign RF_s0      = rf_s_q[0];
    assign alu_s1     = alu_s_q[1];
    assign alu_s0     = alu_s_q[0];
    assign halted     = halted_q;

endmodule

// File: tb/tb_controller.sv
// tb/tb_controller.sv - Directed self-checking bench for controller
module tb_controller;

    typedef struct packed {
        logic       i_rd;
        logic [7:0] i_addr;
        logic [7:0] d_addr;
        logic       d_rd;
        logic       d_wr;
        logic [7:0] w_data;
        logic [3:0] w_addr;
        logic       w_wr;
        logic [3:0] p_addr;
        logic       p_rd;
        logic [3:0] q_addr;
        logic       q_rd;
        logic       s1;
        logic       s0;
        logic       a1;
        logic       a0;
        logic       halted;
    } outs_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  I_addr;
    logic        I_rd;
    logic [15:0] I_data;
    logic [7:0]  D_addr;
    logic        D_rd;
    logic        D_wr;
    logic [7:0]  RF_W_data;
    logic [3:0]  RF_W_addr;
    logic        RF_W_wr;
    logic [3:0]  RF_Rp_addr;
    logic        RF_Rp_rd;
    logic [3:0]  RF_Rq_addr;
    logic        RF_Rq_rd;
    logic        RF_s1;
    logic        RF_s0;
    logic        alu_s1;
    logic        alu_s0;
    logic        RF_Rp_zero;
    logic        halted;

    logic [15:0] mem [256];
    outs_t       obs;
    outs_t       e;
    int          n_run;
    int          n_fail;
    logic        found;

    controller #(.PC_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .I_addr     (I_addr),
        .I_rd       (I_rd),
        .I_data     (I_data),
        .D_addr     (D_addr),
        .D_rd       (D_rd),
        .D_wr       (D_wr),
        .RF_W_data  (RF_W_data),
        .RF_W_addr  (RF_W_addr),
        .RF_W_wr    (RF_W_wr),
        .RF_Rp_addr (RF_Rp_addr),
        .RF_Rp_rd   (RF_Rp_rd),
        .RF_Rq_addr (RF_Rq_addr),
        .RF_Rq_rd   (RF_Rq_rd),
        .RF_s1      (RF_s1),
        .RF_s0      (RF_s0),
        .alu_s1     (alu_s1),
        .alu_s0     (alu_s0),
        .RF_Rp_zero (RF_Rp_zero),
        .halted     (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign I_data = I_rd ? mem[I_addr] : 16'h0000;
    assign obs = {I_rd, I_addr, D_addr, D_rd, D_wr, RF_W_data, RF_W_addr, RF_W_wr,
                  RF_Rp_addr, RF_Rp_rd, RF_Rq_addr, RF_Rq_rd, RF_s1, RF_s0,
                  alu_s1, alu_s0, halted};

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        step();
        step();
        rst = 1'b0;
        e = '0;
        n_run++;
        if (obs !== e) begin n_fail++; $display("FAIL reset_outputs: got %h expected %h", obs, e); end
        for (int k = 0; k < 3; k++) begin
            step();
            n_run++;
            if (obs !== e) begin n_fail++; $display("FAIL init_hold: got %h expected %h", obs, e); end
        end
    endtask

    // start stays high from here on; it must be ignored outside INIT.
    task automatic test_loadc();
        start = 1'b1;
        step();
        e = '0; e.i_rd = 1'b1; e.i_addr = 8'h00;
        n_run++;
        if (obs !== e) begin n_fail++; $display("FAIL fetch0: got %h expected %h", obs, e); end
        step();
        e = '0;
        n_run++;
        if (obs !== e) begin n_fail++; $display("FAIL decode0: got %h expected %h", obs, e); end
        step();
        e = '0; e.w_addr = 4'd1; e.w_data = 8'h05; e.s1 = 1'b1; e.w_wr = 1'b1;
        n_run++;
        if (obs !== e) begin n_fail++; $display("FAIL loadc_exec: got %h expected %h", obs, e); end
    endtask

    task automatic test_load_store();
        step();
        e = '0; e.i_rd = 1'b1; e.i_addr = 8'h01;
        n_run++;
        if (obs !== e) begin n_fail++; $display("FAIL fetch1: got %h expected %h", obs, e); end
        step();
        step();
        e = '0; e.d_addr = 8'h20; e.d_rd = 1'b1; e.w_addr = 4'd2; e.w_wr = 1'b1; e.s0 = 1'b1;
        n_run++;
        if (obs !== e) begin n_fail++; $display("FAIL load_exec: got %h expected %h", obs, e); end
        step();
        step();
        step();
        e = '0; e.d_addr = 8'h20; e.d_wr = 1'b1; e.p_addr = 4'd3; e.p_rd = 1'b1;
        n_run++;
        if (obs !== e) begin n_fail++; $display("FAIL store_exec: got %h expected %h", obs, e); end
    endtask

    task automatic test_add_sub();
        step();
        e = '0; e.i_rd = 1'b1; e.i_addr = 8'h03;
        n_run++;
        if (obs !== e) begin n_fail++; $display("FAIL fetch3: got %h expected %h", obs, e); end
        step();
        step();
        e = '0; e.p_addr = 4'd1; e.p_rd = 1'b1; e.q_addr = 4'd2; e.q_rd = 1'b1;
        e.w_addr = 4'd4; e.w_wr = 1'b1; e.a0 = 1'b1;
        n_run++;
        if (obs !== e) begin n_fail++; $display("FAIL add_exec: got %h expected %h", obs, e); end
        step();
        step();
        step();
        e = '0; e.p_addr = 4'd1; e.p_rd = 1'b1; e.q_addr = 4'd2; e.q_rd = 1'b1;
        e.w_addr = 4'd4; e.w_wr = 1'b1; e.a1 = 1'b1;
        n_run++;
        if (obs !== e) begin n_fail++; $display("FAIL sub_exec: got %h expected %h", obs, e); end
    endtask

    // Ends sitting in the FETCH cycle of address 6.
    task automatic test_noop();
        step();
        e = '0; e.i_rd = 1'b1; e.i_addr = 8'h05;
        n_run++;
        if (obs !== e) begin n_fail++; $display("FAIL fetch5: got %h expected %h", obs, e); end
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (obs.i_rd) begin
                found = 1'b1;
                break;
            end
            e = '0;
            n_run++;
            if (obs !== e) begin n_fail++; $display("FAIL noop_quiet: got %h expected %h", obs, e); end
        end
        e = '0; e.i_rd = 1'b1; e.i_addr = 8'h06;
        n_run++;
        if (!found || obs !== e) begin n_fail++; $display("FAIL noop_next_fetch: got %h expected %h", obs, e); end
    endtask

    task automatic test_jmpz_taken();
        RF_Rp_zero = 1'b1;
        step();
        e = '0;
        n_run++;
        if (obs !== e) begin n_fail++; $display("FAIL jmpz_decode: got %h expected %h", obs, e); end
        step();
        e = '0; e.p_addr = 4'd5; e.p_rd = 1'b1;
        n_run++;
        if (obs !== e) begin n_fail++; $display("FAIL jmpz_exec_t: got %h expected %h", obs, e); end
        step();
        e = '0;
        n_run++;
        if (obs !== e) begin n_fail++; $display("FAIL jmpz_take: got %h expected %h", obs, e); end
        step();
        e = '0; e.i_rd = 1'b1; e.i_addr = 8'h04;
        n_run++;
        if (obs !== e) begin n_fail++; $display("FAIL jmpz_target: got %h expected %h", obs, e); end
        found = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (obs.i_rd && obs.i_addr == 8'h06) begin
                found = 1'b1;
                break;
            end
        end
        n_run++;
        if (!found) begin n_fail++; $display("FAIL refetch6: got no fetch expected fetch of 06"); end
    endtask

    task automatic test_jmpz_not_taken();
        RF_Rp_zero = 1'b0;
        step();
        step();
        e = '0; e.p_addr = 4'd5; e.p_rd = 1'b1;
        n_run++;
        if (obs !== e) begin n_fail++; $display("FAIL jmpz_exec_nt: got %h expected %h", obs, e); end
        step();
        e = '0; e.i_rd = 1'b1; e.i_addr = 8'h07;
        n_run++;
        if (obs !== e) begin n_fail++; $display("FAIL jmpz_fallthru: got %h expected %h", obs, e); end
    endtask

    task automatic test_halt();
        step();
        for (int k = 0; k < 10; k++) begin
            step();
            e = '0; e.halted = 1'b1;
            n_run++;
            if (obs !== e) begin n_fail++; $display("FAIL halt_hold%0d: got %h expected %h", k, obs, e); end
        end
        rst = 1'b1;
        step();
        rst   = 1'b0;
        start = 1'b0;
        e = '0;
        n_run++;
        if (obs !== e) begin n_fail++; $display("FAIL halt_reset: got %h expected %h", obs, e); end
        step();
        n_run++;
        if (obs !== e) begin n_fail++; $display("FAIL halt_init: got %h expected %h", obs, e); end
        start = 1'b1;
        step();
        e = '0; e.i_rd = 1'b1; e.i_addr = 8'h00;
        n_run++;
        if (obs !== e) begin n_fail++; $display("FAIL restart_pc0: got %h expected %h", obs, e); end
    endtask

    // Starts from the FETCH of address 0 left by test_halt.
    task automatic test_reset_mid_add();
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (obs.w_wr && obs.a0 && !obs.a1) begin
                found = 1'b1;
                break;
            end
        end
        n_run++;
        if (!found) begin n_fail++; $display("FAIL reach_add: got no add cycle expected one"); end
        rst   = 1'b1;
        start = 1'b0;
        step();
        rst = 1'b0;
        e = '0;
        n_run++;
        if (obs !== e) begin n_fail++; $display("FAIL add_abort: got %h expected %h", obs, e); end
        for (int k = 0; k < 5; k++) begin
            step();
            n_run++;
            if (obs !== e) begin n_fail++; $display("FAIL post_abort_quiet: got %h expected %h", obs, e); end
        end
    endtask

    // Backward jump from address 0 to 0xFF, then a no-op that wraps PC to 0.
    task automatic test_pc_wrap();
        mem[0]   = 16'h50FF;
        mem[255] = 16'h7000;
        RF_Rp_zero = 1'b1;
        start = 1'b1;
        step();
        e = '0; e.i_rd = 1'b1; e.i_addr = 8'h00;
        n_run++;
        if (obs !== e) begin n_fail++; $display("FAIL wrap_fetch0: got %h expected %h", obs, e); end
        step();
        step();
        e = '0; e.p_addr = 4'd0; e.p_rd = 1'b1;
        n_run++;
        if (obs !== e) begin n_fail++; $display("FAIL wrap_jmpz: got %h expected %h", obs, e); end
        step();
        step();
        e = '0; e.i_rd = 1'b1; e.i_addr = 8'hFF;
        n_run++;
        if (obs !== e) begin n_fail++; $display("FAIL wrap_fetchff: got %h expected %h", obs, e); end
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (obs.i_rd) begin
                found = 1'b1;
                break;
            end
        end
        e = '0; e.i_rd = 1'b1; e.i_addr = 8'h00;
        n_run++;
        if (!found || obs !== e) begin n_fail++; $display("FAIL wrap_to_zero: got %h expected %h", obs, e); end
    endtask

    initial begin
        n_run  = 0;
        n_fail = 0;
        rst    = 1'b1;
        start  = 1'b0;
        RF_Rp_zero = 1'b0;
        for (int k = 0; k < 256; k++) mem[k] = 16'h7000;
        mem[0] = 16'h3105;
        mem[1] = 16'h0220;
        mem[2] = 16'h1320;
        mem[3] = 16'h2412;
        mem[4] = 16'h4412;
        mem[5] = 16'h7000;
        mem[6] = 16'h55FE;
        mem[7] = 16'hF000;

        test_reset();
        test_loadc();
        test_load_store();
        test_add_sub();
        test_noop();
        test_jmpz_taken();
        test_jmpz_not_taken();
        test_halt();
        test_reset_mid_add();
        test_pc_wrap();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
